// File: rtl/ic_registry_rd_if.sv
// Read-path bookkeeping bus for ic_registry_rd.
// Groups the master-side and slave-side AR/R handshake observations the
// registry samples and the routing information it returns.
// The "slave" modport is the registry itself. The "master" modport is the
// interconnect fabric that drives the handshakes and consumes the routing
// outputs.
// Handshake semantics: a transfer happens on a rising clk edge where VALID
// and READY are both high. A burst ends on the R transfer that also has
// RLAST high. VALID/READY are only observed here; the registry never
// stalls them. ARFULL tells the fabric to hold ARREADY low.
interface ic_registry_rd_if;
    logic       M0_ARVALID, M0_ARREADY;
    logic [1:0] M0_ARSLV;
    logic       M0_RVALID, M0_RREADY, M0_RLAST;
    logic [1:0] M0_RSLV;
    logic       M0_ROK, M0_ARFULL;

    logic       M1_ARVALID, M1_ARREADY;
    logic [1:0] M1_ARSLV;
    logic       M1_RVALID, M1_RREADY, M1_RLAST;
    logic [1:0] M1_RSLV;
    logic       M1_ROK, M1_ARFULL;

    logic       S0_ARVALID, S0_ARREADY, S0_ARMSTR;
    logic       S0_RVALID, S0_RREADY, S0_RLAST;
    logic       S0_RMSTR, S0_RMSTR_VLD;

    logic       S1_ARVALID, S1_ARREADY, S1_ARMSTR;
    logic       S1_RVALID, S1_RREADY, S1_RLAST;
    logic       S1_RMSTR, S1_RMSTR_VLD;

    modport master (
        output M0_ARVALID, M0_ARREADY, M0_ARSLV, M0_RVALID, M0_RREADY, M0_RLAST,
        output M1_ARVALID, M1_ARREADY, M1_ARSLV, M1_RVALID, M1_RREADY, M1_RLAST,
        output S0_ARVALID, S0_ARREADY, S0_ARMSTR, S0_RVALID, S0_RREADY, S0_RLAST,
        output S1_ARVALID, S1_ARREADY, S1_ARMSTR, S1_RVALID, S1_RREADY, S1_RLAST,
        input  M0_RSLV, M0_ROK, M0_ARFULL, M1_RSLV, M1_ROK, M1_ARFULL,
        input  S0_RMSTR, S0_RMSTR_VLD, S1_RMSTR, S1_RMSTR_VLD
    );

    modport slave (
        input  M0_ARVALID, M0_ARREADY, M0_ARSLV, M0_RVALID, M0_RREADY, M0_RLAST,
        input  M1_ARVALID, M1_ARREADY, M1_ARSLV, M1_RVALID, M1_RREADY, M1_RLAST,
        input  S0_ARVALID, S0_ARREADY, S0_ARMSTR, S0_RVALID, S0_RREADY, S0_RLAST,
        input  S1_ARVALID, S1_ARREADY, S1_ARMSTR, S1_RVALID, S1_RREADY, S1_RLAST,
        output M0_RSLV, M0_ROK, M0_ARFULL, M1_RSLV, M1_ROK, M1_ARFULL,
        output S0_RMSTR, S0_RMSTR_VLD, S1_RMSTR, S1_RMSTR_VLD
    );
endinterface

// File: rtl/ic_registry_rd.sv
// Outstanding-read registry for a 2-master / 2-slave interconnect.
// Each master keeps an in-order FIFO of target slaves (2 = decode-error
// responder). Each slave keeps an in-order FIFO of issuing masters.
// The FIFO heads tell the R path which slave owes a master its next burst,
// and whether that slave is currently serving that master.
// Optional feature macro: IC_REGISTRY_RD_ERR_CHK_EN adds a sticky ERR output
// that flags push-when-full / pop-when-empty on any FIFO.
// A push on a full FIFO is accepted only when the same FIFO pops in that
// cycle. A pop on an empty FIFO is always dropped, even alongside a push.
module ic_registry_rd #(
    parameter int CMD_DEPTH  = 4,
    parameter int MSTR_DEPTH = 8
) (
    input logic clk,
    input logic reset,
    ic_registry_rd_if.slave bus
`ifdef IC_REGISTRY_RD_ERR_CHK_EN
    ,
    output logic ERR
`endif
);
    localparam int MW = $clog2(CMD_DEPTH);
    localparam int SW = $clog2(MSTR_DEPTH);
    localparam logic [MW:0]   M_FULL    = (MW+1)'(CMD_DEPTH);
    localparam logic [MW:0]   M_CNT_ONE = (MW+1)'(1);
    localparam logic [MW-1:0] M_PTR_ONE = MW'(1);
    localparam logic [SW:0]   S_FULL    = (SW+1)'(MSTR_DEPTH);
    localparam logic [SW:0]   S_CNT_ONE = (SW+1)'(1);
    localparam logic [SW-1:0] S_PTR_ONE = SW'(1);

    // Handshake decode, gathered into per-index vectors
    logic [1:0] m_push, m_pop, s_push, s_pop, s_push_mstr;
    logic [1:0] m_push_slv [2];

    assign m_push[0]     = bus.M0_ARVALID & bus.M0_ARREADY;
    assign m_push[1]     = bus.M1_ARVALID & bus.M1_ARREADY;
    assign m_pop[0]      = bus.M0_RVALID & bus.M0_RREADY & bus.M0_RLAST;
    assign m_pop[1]      = bus.M1_RVALID & bus.M1_RREADY & bus.M1_RLAST;
    assign m_push_slv[0] = bus.M0_ARSLV;
    assign m_push_slv[1] = bus.M1_ARSLV;
    assign s_push[0]     = bus.S0_ARVALID & bus.S0_ARREADY;
    assign s_push[1]     = bus.S1_ARVALID & bus.S1_ARREADY;
    assign s_pop[0]      = bus.S0_RVALID & bus.S0_RREADY & bus.S0_RLAST;
    assign s_pop[1]      = bus.S1_RVALID & bus.S1_RREADY & bus.S1_RLAST;
    assign s_push_mstr   = {bus.S1_ARMSTR, bus.S0_ARMSTR};

    logic [1:0]    m_mem_q [2][CMD_DEPTH];
    logic [1:0]    m_mem_d [2][CMD_DEPTH];
    logic [MW-1:0] m_rd_q [2], m_rd_d [2], m_wr_q [2], m_wr_d [2];
    logic [MW:0]   m_cnt_q [2], m_cnt_d [2];
    logic          s_mem_q [2][MSTR_DEPTH];
    logic          s_mem_d [2][MSTR_DEPTH];
    logic [SW-1:0] s_rd_q [2], s_rd_d [2], s_wr_q [2], s_wr_d [2];
    logic [SW:0]   s_cnt_q [2], s_cnt_d [2];
    logic [1:0]    m_push_ok, m_pop_ok, s_push_ok, s_pop_ok;

    // Accept/drop decision per FIFO: pop needs data, push needs room or a pop
    always_comb begin
        m_push_ok = '0;
        m_pop_ok  = '0;
        s_push_ok = '0;
        s_pop_ok  = '0;
        for (int i = 0; i < 2; i++) begin
            m_pop_ok[i]  = m_pop[i] && (m_cnt_q[i] != '0);
            m_push_ok[i] = m_push[i] && ((m_cnt_q[i] != M_FULL) || m_pop_ok[i]);
            s_pop_ok[i]  = s_pop[i] && (s_cnt_q[i] != '0);
            s_push_ok[i] = s_push[i] && ((s_cnt_q[i] != S_FULL) || s_pop_ok[i]);
        end
    end

    // Next FIFO state: write at tail, advance head, track occupancy
    always_comb begin
        m_mem_d = m_mem_q;
        m_rd_d  = m_rd_q;
        m_wr_d  = m_wr_q;
        m_cnt_d = m_cnt_q;
        s_mem_d = s_mem_q;
        s_rd_d  = s_rd_q;
        s_wr_d  = s_wr_q;
        s_cnt_d = s_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (m_push_ok[i]) begin
                m_mem_d[i][m_wr_q[i]] = m_push_slv[i];
                m_wr_d[i] = m_wr_q[i] + M_PTR_ONE;
            end
            if (m_pop_ok[i]) m_rd_d[i] = m_rd_q[i] + M_PTR_ONE;
            if (m_push_ok[i] && !m_pop_ok[i])      m_cnt_d[i] = m_cnt_q[i] + M_CNT_ONE;
            else if (!m_push_ok[i] && m_pop_ok[i]) m_cnt_d[i] = m_cnt_q[i] - M_CNT_ONE;

            if (s_push_ok[i]) begin
                s_mem_d[i][s_wr_q[i]] = s_push_mstr[i];
                s_wr_d[i] = s_wr_q[i] + S_PTR_ONE;
            end
            if (s_pop_ok[i]) s_rd_d[i] = s_rd_q[i] + S_PTR_ONE;
            if (s_push_ok[i] && !s_pop_ok[i])      s_cnt_d[i] = s_cnt_q[i] + S_CNT_ONE;
            else if (!s_push_ok[i] && s_pop_ok[i]) s_cnt_d[i] = s_cnt_q[i] - S_CNT_ONE;
        end
    end

    // FIFO state registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < CMD_DEPTH; j++)  m_mem_q[i][j] <= '0;
                for (int j = 0; j < MSTR_DEPTH; j++) s_mem_q[i][j] <= 1'b0;
                m_rd_q[i]  <= '0;
                m_wr_q[i]  <= '0;
                m_cnt_q[i] <= '0;
                s_rd_q[i]  <= '0;
                s_wr_q[i]  <= '0;
                s_cnt_q[i] <= '0;
            end
        end else begin
            m_mem_q <= m_mem_d;
            m_rd_q  <= m_rd_d;
            m_wr_q  <= m_wr_d;
            m_cnt_q <= m_cnt_d;
            s_mem_q <= s_mem_d;
            s_rd_q  <= s_rd_d;
            s_wr_q  <= s_wr_d;
            s_cnt_q <= s_cnt_d;
        end
    end

    logic [1:0] m_rslv [2];
    logic [1:0] m_rok, m_full, s_rmstr, s_vld;

    // Routing outputs decoded from registered FIFO heads
    always_comb begin
        s_vld   = '0;
        s_rmstr = '0;
        m_rok   = '0;
        m_full  = '0;
        m_rslv  = '{2'd3, 2'd3};
        for (int i = 0; i < 2; i++) begin
            s_vld[i]   = (s_cnt_q[i] != '0);
            s_rmstr[i] = s_vld[i] ? s_mem_q[i][s_rd_q[i]] : 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            m_full[i] = (m_cnt_q[i] == M_FULL);
            if (m_cnt_q[i] != '0) m_rslv[i] = m_mem_q[i][m_rd_q[i]];
            case (m_rslv[i])
                2'd2:       m_rok[i] = 1'b1;
                2'd0, 2'd1: m_rok[i] = s_vld[m_rslv[i][0]] && (s_rmstr[m_rslv[i][0]] == i[0]);
                default:    m_rok[i] = 1'b0;
            endcase
        end
    end

    assign bus.M0_RSLV      = m_rslv[0];
    assign bus.M0_ROK       = m_rok[0];
    assign bus.M0_ARFULL    = m_full[0];
    assign bus.M1_RSLV      = m_rslv[1];
    assign bus.M1_ROK       = m_rok[1];
    assign bus.M1_ARFULL    = m_full[1];
    assign bus.S0_RMSTR     = s_rmstr[0];
    assign bus.S0_RMSTR_VLD = s_vld[0];
    assign bus.S1_RMSTR     = s_rmstr[1];
    assign bus.S1_RMSTR_VLD = s_vld[1];

`ifdef IC_REGISTRY_RD_ERR_CHK_EN
    logic err_q, err_d;

    // Sticky misuse flag: any dropped push or dropped pop
    always_comb begin
        err_d = err_q | (|(m_push & ~m_push_ok)) | (|(m_pop & ~m_pop_ok))
                      | (|(s_push & ~s_push_ok)) | (|(s_pop & ~s_pop_ok));
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign ERR = err_q;
`endif
endmodule

// File: tb/tb_ic_registry_rd.sv
// Bench for ic_registry_rd: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the outstanding reads.
// Optional feature macro: IC_REGISTRY_RD_ERR_CHK_EN (ERR flag checks).
module tb_ic_registry_rd;
  localparam int CMD_DEPTH  = 4;
  localparam int MSTR_DEPTH = 8;
  localparam logic [11:0] RST_VEC = 12'hCC0;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // driven stimulus
  logic [1:0] m_arv = '0, m_arr = '0, m_rv = '0, m_rr = '0, m_rl = '0;
  logic [1:0] m_arslv [2];
  logic [1:0] s_arv = '0, s_arr = '0, s_armstr = '0, s_rv = '0, s_rr = '0, s_rl = '0;

  ic_registry_rd_if bus ();

  assign bus.M0_ARVALID = m_arv[0];
  assign bus.M0_ARREADY = m_arr[0];
  assign bus.M0_ARSLV   = m_arslv[0];
  assign bus.M0_RVALID  = m_rv[0];
  assign bus.M0_RREADY  = m_rr[0];
  assign bus.M0_RLAST   = m_rl[0];
  assign bus.M1_ARVALID = m_arv[1];
  assign bus.M1_ARREADY = m_arr[1];
  assign bus.M1_ARSLV   = m_arslv[1];
  assign bus.M1_RVALID  = m_rv[1];
  assign bus.M1_RREADY  = m_rr[1];
  assign bus.M1_RLAST   = m_rl[1];
  assign bus.S0_ARVALID = s_arv[0];
  assign bus.S0_ARREADY = s_arr[0];
  assign bus.S0_ARMSTR  = s_armstr[0];
  assign bus.S0_RVALID  = s_rv[0];
  assign bus.S0_RREADY  = s_rr[0];
  assign bus.S0_RLAST   = s_rl[0];
  assign bus.S1_ARVALID = s_arv[1];
  assign bus.S1_ARREADY = s_arr[1];
  assign bus.S1_ARMSTR  = s_armstr[1];
  assign bus.S1_RVALID  = s_rv[1];
  assign bus.S1_RREADY  = s_rr[1];
  assign bus.S1_RLAST   = s_rl[1];

`ifdef IC_REGISTRY_RD_ERR_CHK_EN
  logic err;
  ic_registry_rd #(.CMD_DEPTH(CMD_DEPTH), .MSTR_DEPTH(MSTR_DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .ERR(err)
  );
`else
  ic_registry_rd #(.CMD_DEPTH(CMD_DEPTH), .MSTR_DEPTH(MSTR_DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
`endif

  // all observable routing outputs in one vector
  logic [11:0] obs;
  assign obs = {bus.M0_RSLV, bus.M0_ROK, bus.M0_ARFULL,
                bus.M1_RSLV, bus.M1_ROK, bus.M1_ARFULL,
                bus.S0_RMSTR, bus.S0_RMSTR_VLD, bus.S1_RMSTR, bus.S1_RMSTR_VLD};

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: outstanding reads as ordered queues
  logic [1:0] mq [2][$];
  logic       sq [2][$];
  logic       exp_err = 1'b0;

  function automatic logic [11:0] exp_vec();
    logic [1:0] r [2];
    logic ok [2], full [2], sm [2], sv [2];
    for (int y = 0; y < 2; y++) begin
      sv[y] = (sq[y].size() != 0);
      sm[y] = sv[y] ? sq[y][0] : 1'b0;
    end
    for (int x = 0; x < 2; x++) begin
      r[x]    = (mq[x].size() != 0) ? mq[x][0] : 2'd3;
      full[x] = (mq[x].size() == CMD_DEPTH);
      if (r[x] == 2'd2)     ok[x] = 1'b1;
      else if (r[x] == 2'd3) ok[x] = 1'b0;
      else                  ok[x] = sv[r[x][0]] && (sm[r[x][0]] == (x == 1));
    end
    return {r[0], ok[0], full[0], r[1], ok[1], full[1], sm[0], sv[0], sm[1], sv[1]};
  endfunction

  // one clock of transfers: retire bursts first, then accept new commands
  task automatic model_update();
    for (int x = 0; x < 2; x++) begin
      if (m_rv[x] && m_rr[x] && m_rl[x]) begin
        if (mq[x].size() > 0) void'(mq[x].pop_front());
        else exp_err = 1'b1;
      end
      if (m_arv[x] && m_arr[x]) begin
        if (mq[x].size() < CMD_DEPTH) mq[x].push_back(m_arslv[x]);
        else exp_err = 1'b1;
      end
      if (s_rv[x] && s_rr[x] && s_rl[x]) begin
        if (sq[x].size() > 0) void'(sq[x].pop_front());
        else exp_err = 1'b1;
      end
      if (s_arv[x] && s_arr[x]) begin
        if (sq[x].size() < MSTR_DEPTH) sq[x].push_back(s_armstr[x]);
        else exp_err = 1'b1;
      end
    end
  endtask

  task automatic idle_inputs();
    m_arv = '0; m_arr = '0; m_rv = '0; m_rr = '0; m_rl = '0;
    m_arslv[0] = '0; m_arslv[1] = '0;
    s_arv = '0; s_arr = '0; s_armstr = '0; s_rv = '0; s_rr = '0; s_rl = '0;
  endtask

  task automatic clear_model();
    for (int x = 0; x < 2; x++) begin
      mq[x].delete();
      sq[x].delete();
    end
    exp_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic m_ar(input int x, input logic [1:0] slv);
    m_arv[x] = 1'b1; m_arr[x] = 1'b1; m_arslv[x] = slv;
  endtask

  task automatic s_ar(input int y, input logic mstr);
    s_arv[y] = 1'b1; s_arr[y] = 1'b1; s_armstr[y] = mstr;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL reset_outputs: got %h want %h", obs, RST_VEC);
    else n_pass++;
    step();
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL idle_after_reset: got %h want %h", obs, RST_VEC);
    else n_pass++;
  endtask

  task automatic test_single_burst();
    do_reset();
    m_ar(0, 2'd1);
    s_ar(1, 1'b0);
    step();
    idle_inputs();
    n_checks++;
    if ({bus.M0_RSLV, bus.M0_ROK, bus.S1_RMSTR, bus.S1_RMSTR_VLD} !== 5'b01101)
      $display("FAIL single_ar_route: got %b want 01101",
               {bus.M0_RSLV, bus.M0_ROK, bus.S1_RMSTR, bus.S1_RMSTR_VLD});
    else n_pass++;
    for (int b = 0; b < 4; b++) begin
      m_rv[0] = 1'b1; m_rr[0] = 1'b1; m_rl[0] = (b == 3);
      s_rv[1] = 1'b1; s_rr[1] = 1'b1; s_rl[1] = (b == 3);
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL single_burst_beat%0d: got %h want %h", b, obs, exp_vec());
      else n_pass++;
    end
    idle_inputs();
    n_checks++;
    if ({bus.M0_RSLV, bus.S1_RMSTR_VLD} !== 3'b110)
      $display("FAIL single_burst_done: got %b want 110", {bus.M0_RSLV, bus.S1_RMSTR_VLD});
    else n_pass++;
  endtask

  task automatic test_slave_order();
    do_reset();
    m_ar(1, 2'd0); s_ar(0, 1'b1);
    step();
    idle_inputs();
    m_ar(0, 2'd0); s_ar(0, 1'b0);
    step();
    idle_inputs();
    n_checks++;
    if ({bus.M0_ROK, bus.M1_ROK} !== 2'b01)
      $display("FAIL order_wait: got %b want 01", {bus.M0_ROK, bus.M1_ROK});
    else n_pass++;
    repeat (2) step();
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL order_hold: got %h want %h", obs, exp_vec());
    else n_pass++;
    m_rv[1] = 1'b1; m_rr[1] = 1'b1; m_rl[1] = 1'b1;
    s_rv[0] = 1'b1; s_rr[0] = 1'b1; s_rl[0] = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if ({bus.M0_ROK, bus.M0_RSLV, bus.M1_RSLV} !== 5'b1_00_11)
      $display("FAIL order_handover: got %b want 10011", {bus.M0_ROK, bus.M0_RSLV, bus.M1_RSLV});
    else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [1:0] seq [4];
    seq = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_ar(0, seq[i]);
      step();
    end
    idle_inputs();
    n_checks++;
    if ({bus.M0_ARFULL, bus.M0_RSLV} !== 3'b100)
      $display("FAIL full_flag: got %b want 100", {bus.M0_ARFULL, bus.M0_RSLV});
    else n_pass++;
    m_ar(0, 2'd1);
    m_rv[0] = 1'b1; m_rr[0] = 1'b1; m_rl[0] = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if ({bus.M0_ARFULL, bus.M0_RSLV} !== 3'b101)
      $display("FAIL full_pushpop: got %b want 101", {bus.M0_ARFULL, bus.M0_RSLV});
    else n_pass++;
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL full_pushpop_all: got %h want %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_decode_err();
    do_reset();
    m_ar(1, 2'd2);
    step();
    idle_inputs();
    n_checks++;
    if ({bus.M1_RSLV, bus.M1_ROK, bus.S0_RMSTR_VLD, bus.S1_RMSTR_VLD} !== 5'b10100)
      $display("FAIL serr_route: got %b want 10100",
               {bus.M1_RSLV, bus.M1_ROK, bus.S0_RMSTR_VLD, bus.S1_RMSTR_VLD});
    else n_pass++;
  endtask

  task automatic test_random();
    int pop_pct;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      pop_pct = ((c / 100) % 2 == 0) ? 15 : 55;
      for (int x = 0; x < 2; x++) begin
        m_arv[x]    = ($urandom_range(0, 99) < 45);
        m_arr[x]    = ($urandom_range(0, 99) < 80);
        m_arslv[x]  = 2'($urandom_range(0, 2));
        m_rv[x]     = ($urandom_range(0, 99) < 70);
        m_rr[x]     = ($urandom_range(0, 99) < 80);
        m_rl[x]     = ($urandom_range(0, 99) < pop_pct);
        s_arv[x]    = ($urandom_range(0, 99) < 45);
        s_arr[x]    = ($urandom_range(0, 99) < 80);
        s_armstr[x] = 1'($urandom_range(0, 1));
        s_rv[x]     = ($urandom_range(0, 99) < 70);
        s_rr[x]     = ($urandom_range(0, 99) < 80);
        s_rl[x]     = ($urandom_range(0, 99) < pop_pct);
      end
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random_c%0d: got %h want %h", c, obs, exp_vec());
      else n_pass++;
`ifdef IC_REGISTRY_RD_ERR_CHK_EN
      n_checks++;
      if (err !== exp_err) $display("FAIL random_err_c%0d: got %b want %b", c, err, exp_err);
      else n_pass++;
`endif
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_ar(0, 2'd1); s_ar(1, 1'b0); m_ar(1, 2'd2);
    repeat (3) step();
    @(posedge clk);
    #3;
    reset = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL async_reset: got %h want %h", obs, RST_VEC);
    else n_pass++;
    repeat (2) step();
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL reset_discard: got %h want %h", obs, RST_VEC);
    else n_pass++;
    idle_inputs();
    reset = 1'b1;
    step();
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL after_reset_release: got %h want %h", obs, RST_VEC);
    else n_pass++;
  endtask

`ifdef IC_REGISTRY_RD_ERR_CHK_EN
  task automatic test_err_flag();
    do_reset();
    s_rv[0] = 1'b1; s_rr[0] = 1'b1; s_rl[0] = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err);
    else n_pass++;
    m_ar(0, 2'd0); s_ar(0, 1'b0);
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    m_rv[0] = 1'b1; m_rr[0] = 1'b1; m_rl[0] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if ({err, obs} !== {1'b0, RST_VEC}) $display("FAIL err_async_reset: got %h want %h", {err, obs}, {1'b0, RST_VEC});
    else n_pass++;
    idle_inputs();
    step();
    reset = 1'b1;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single_burst();
    test_slave_order();
    test_full_pushpop();
    test_decode_err();
    test_random();
    test_async_reset();
`ifdef IC_REGISTRY_RD_ERR_CHK_EN
    test_err_flag();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
